// File: rtl/hazard_sched_if.sv
// Hazard scheduler bus: D/E/M stage hazard information in, stall and
// multiply/divide status out. The pipeline control side is the master,
// the scheduler is the slave.
interface hazard_sched_if;
  logic [4:0] D_rs_addr;
  logic [4:0] D_rt_addr;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic       D_is_md;
  logic [4:0] E_A3;
  logic [1:0] E_Tnew;
  logic [4:0] M_A3;
  logic [1:0] M_Tnew;
  logic       E_md_start;
  logic       E_md_op;
  logic       Stall;
  logic       E_RegE_Clr;
  logic       md_busy;
  logic       md_done;
  logic [3:0] md_cnt;
  logic       md_overlap_err;

  modport master (
    output D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_is_md,
    output E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_op,
    input  Stall, E_RegE_Clr, md_busy, md_done, md_cnt, md_overlap_err
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_is_md,
    input  E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_op,
    output Stall, E_RegE_Clr, md_busy, md_done, md_cnt, md_overlap_err
  );
endinterface

// File: rtl/hazard_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline. Resolves
// register-read hazards with Tuse/Tnew against E and M, and sequences the
// multi-cycle multiply/divide unit, holding D-stage md instructions back
// until the unit is free.
module hazard_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          Clk,
  input logic          Reset,
  hazard_sched_if.slave hs
);

  // The busy counter is 4 bits wide, so both latencies must fit in 1..15.
  generate
    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
      $error("hazard_sched: MULT_CYCLES must be in the range 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
      $error("hazard_sched: DIV_CYCLES must be in the range 1..15");
    end
  endgenerate

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t  md_state_q, md_state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_done_q, md_done_d;
  logic       md_err_q, md_err_d;

  logic       stall_rs;
  logic       stall_rt;
  logic       md_stall;
  logic       stall_any;

  // Multiply/divide sequencer registers; reset wins over any count in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= 4'd0;
      md_done_q  <= 1'b0;
      md_err_q   <= 1'b0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
      md_done_q  <= md_done_d;
      md_err_q   <= md_err_d;
    end
  end

  // Sequencer next state: load on start, count down while busy, pulse done on the last count.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    md_done_d  = 1'b0;
    md_err_d   = md_err_q;
    case (md_state_q)
      MD_IDLE: begin
        if (hs.E_md_start) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = hs.E_md_op ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (hs.E_md_start) begin
          md_err_d = 1'b1;
        end
        if (md_cnt_q > 4'd1) begin
          md_cnt_d = md_cnt_q - 4'd1;
        end else begin
          md_cnt_d   = 4'd0;
          md_state_d = MD_IDLE;
          md_done_d  = 1'b1;
        end
      end
      default: begin
        md_state_d = MD_IDLE;
        md_cnt_d   = 4'd0;
      end
    endcase
  end

  // Stall decision: a source register still being produced too late for its use, or an md op that cannot enter the unit yet.
  always_comb begin
    stall_rs = (hs.D_rs_addr != 5'd0) &&
               (((hs.D_rs_addr == hs.E_A3) && (hs.E_Tnew > hs.D_Tuse_rs)) ||
                ((hs.D_rs_addr == hs.M_A3) && (hs.M_Tnew > hs.D_Tuse_rs)));
    stall_rt = (hs.D_rt_addr != 5'd0) &&
               (((hs.D_rt_addr == hs.E_A3) && (hs.E_Tnew > hs.D_Tuse_rt)) ||
                ((hs.D_rt_addr == hs.M_A3) && (hs.M_Tnew > hs.D_Tuse_rt)));
    md_stall  = hs.D_is_md && ((md_state_q == MD_BUSY) || hs.E_md_start);
    stall_any = !Reset && (stall_rs || stall_rt || md_stall);
  end

  assign hs.Stall          = stall_any;
  assign hs.E_RegE_Clr     = stall_any;
  assign hs.md_busy        = (md_state_q == MD_BUSY);
  assign hs.md_done        = md_done_q;
  assign hs.md_cnt         = md_cnt_q;
  assign hs.md_overlap_err = md_err_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Testbench for hazard_sched: directed scenarios with hand-derived
// expectations, then randomized traffic against a timestamp-based model of
// the multiply/divide unit and the Tuse/Tnew stall rule.
module tb_hazard_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic Clk;
  logic Reset;

  hazard_sched_if bus ();

  hazard_sched #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .hs   (bus)
  );

  int n_cmp;
  int n_fail;

  // Model: the unit is described by the cycle its accepted start edge closed
  // and the latency of that op, rather than by a counter.
  int cyc;
  bit m_have;
  int m_start;
  int m_n;
  bit m_err;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic bit m_busy();
    return m_have && (cyc > m_start) && (cyc <= m_start + m_n);
  endfunction

  function automatic int m_cnt();
    return m_busy() ? (m_start + m_n + 1 - cyc) : 0;
  endfunction

  function automatic bit m_done();
    return m_have && (cyc == m_start + m_n + 1);
  endfunction

  function automatic bit hz(input logic [4:0] a, input logic [1:0] tuse);
    return (a != 5'd0) &&
           (((a == bus.E_A3) && (int'(bus.E_Tnew) > int'(tuse))) ||
            ((a == bus.M_A3) && (int'(bus.M_Tnew) > int'(tuse))));
  endfunction

  function automatic bit m_stall();
    return !Reset && (hz(bus.D_rs_addr, bus.D_Tuse_rs) || hz(bus.D_rt_addr, bus.D_Tuse_rt) ||
                      (bus.D_is_md && (m_busy() || bus.E_md_start)));
  endfunction

  // {Stall, E_RegE_Clr, md_busy, md_done, md_cnt, md_overlap_err}
  function automatic logic [8:0] model_vec();
    logic s;
    s = m_stall();
    return {s, s, m_busy(), m_done(), 4'(m_cnt()), m_err};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.Stall, bus.E_RegE_Clr, bus.md_busy, bus.md_done, bus.md_cnt, bus.md_overlap_err};
  endfunction

  task automatic applyStimulus(input logic [4:0] rs, input logic [1:0] tuse_rs,
                               input logic [4:0] rt, input logic [1:0] tuse_rt,
                               input logic is_md,
                               input logic [4:0] e_a3, input logic [1:0] e_tnew,
                               input logic [4:0] m_a3, input logic [1:0] m_tnew,
                               input logic md_start, input logic md_op);
    bus.D_rs_addr  = rs;
    bus.D_Tuse_rs  = tuse_rs;
    bus.D_rt_addr  = rt;
    bus.D_Tuse_rt  = tuse_rt;
    bus.D_is_md    = is_md;
    bus.E_A3       = e_a3;
    bus.E_Tnew     = e_tnew;
    bus.M_A3       = m_a3;
    bus.M_Tnew     = m_tnew;
    bus.E_md_start = md_start;
    bus.E_md_op    = md_op;
    #1;
  endtask

  task automatic idle_inputs();
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // One clock edge; the model advances from the inputs held across that edge.
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      m_have = 1'b0;
      m_err  = 1'b0;
    end else if (bus.E_md_start) begin
      if (m_busy()) begin
        m_err = 1'b1;
      end else begin
        m_have  = 1'b1;
        m_start = cyc;
        m_n     = bus.E_md_op ? DIV_N : MULT_N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    Reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    obs = dut_vec();
    if (obs !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %b expected %b", obs, 9'b0);
    end
    Reset = 1'b0;
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    obs = dut_vec();
    if ({obs[6], obs[4:0]} !== {1'b1, 4'd7, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_busy7: got busy=%b cnt=%0d err=%b expected busy=1 cnt=7 err=1",
               obs[6], obs[4:1], obs[0]);
    end
    Reset = 1'b1;
    applyStimulus(5'd1, 2'd0, 5'd0, 2'd3, 1'b1, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Stall, bus.E_RegE_Clr} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_comb_stall: got %b expected 00", {bus.Stall, bus.E_RegE_Clr});
    end
    tick();
    n_cmp++;
    obs = dut_vec();
    if (obs !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_busy: got %b expected %b", obs, 9'b0);
    end
    tick();
    Reset = 1'b0;
    idle_inputs();
    tick();
    n_cmp++;
    obs = dut_vec();
    if (obs !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_after_release: got %b expected %b", obs, 9'b0);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(5'd1, 2'd0, 5'd2, 2'd3, 1'b0, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Stall, bus.E_RegE_Clr} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL load_use_E: got %b expected 11", {bus.Stall, bus.E_RegE_Clr});
    end
    tick();
    applyStimulus(5'd1, 2'd0, 5'd2, 2'd3, 1'b0, 5'd0, 2'd0, 5'd1, 2'd1, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Stall, bus.E_RegE_Clr} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL load_use_M: got %b expected 11", {bus.Stall, bus.E_RegE_Clr});
    end
    tick();
    applyStimulus(5'd1, 2'd0, 5'd2, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Stall, bus.E_RegE_Clr} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL load_use_release: got %b expected 00", {bus.Stall, bus.E_RegE_Clr});
    end
    applyStimulus(5'd1, 2'd0, 5'd2, 2'd3, 1'b0, 5'd0, 2'd0, 5'd1, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tnew0_forward: got %b expected 0", bus.Stall);
    end
    tick();
  endtask

  task automatic test_zero_and_unused();
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    exp_v = 5'b00110;
    applyStimulus(5'd0, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    obs_v[4] = bus.Stall;
    applyStimulus(5'd0, 2'd3, 5'd5, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    obs_v[3] = bus.Stall;
    applyStimulus(5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    obs_v[2] = bus.Stall;
    applyStimulus(5'd0, 2'd3, 5'd6, 2'd1, 1'b0, 5'd0, 2'd0, 5'd6, 2'd2, 1'b0, 1'b0);
    obs_v[1] = bus.Stall;
    applyStimulus(5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    obs_v[0] = bus.Stall;
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL zero_unused_boundary: got %b expected %b", obs_v, exp_v);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_div_window();
    logic [6:0] obs;
    logic [6:0] exp;
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    n_cmp++;
    if (bus.Stall !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL div_start_stall: got %b expected 1", bus.Stall);
    end
    tick();
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < DIV_N + 2; i++) begin
      obs = {bus.Stall, bus.md_busy, bus.md_done, bus.md_cnt};
      if (i < DIV_N)       exp = {1'b1, 1'b1, 1'b0, 4'(DIV_N - i)};
      else if (i == DIV_N) exp = {1'b0, 1'b0, 1'b1, 4'd0};
      else                 exp = {1'b0, 1'b0, 1'b0, 4'd0};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL div_window[%0d]: got stall/busy/done/cnt %b expected %b", i, obs, exp);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_mult_overlap();
    logic [7:0] obs;
    logic [7:0] exp;
    // Each row: E_md_start applied this cycle, then expected {busy, done, cnt, err, pad}.
    logic [7:0] exp_tab [10];
    logic       start_tab [10];
    exp_tab = '{8'b1_0_0101_0_0, 8'b1_0_0100_0_0, 8'b1_0_0011_1_0, 8'b1_0_0010_1_0,
                8'b1_0_0001_1_0, 8'b0_1_0000_1_0, 8'b1_0_0101_1_0, 8'b1_0_0100_1_0,
                8'b1_0_0011_1_0, 8'b1_0_0010_1_0};
    start_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, start_tab[i], 1'b0);
      obs = {bus.md_busy, bus.md_done, bus.md_cnt, bus.md_overlap_err, 1'b0};
      exp = exp_tab[i];
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL mult_overlap[%0d]: got busy/done/cnt/err %b expected %b", i, obs, exp);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_combined();
    logic [1:0] obs;
    logic       hz_on;
    logic       exp_s;
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= DIV_N + 2; i++) begin
      hz_on = (i <= 3) || (i == DIV_N + 1);
      applyStimulus(5'd3, 2'd0, 5'd0, 2'd3, 1'b1, hz_on ? 5'd3 : 5'd0, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
      exp_s = (i <= DIV_N + 1);
      obs = {bus.Stall, bus.E_RegE_Clr};
      n_cmp++;
      if (obs !== {exp_s, exp_s}) begin
        n_fail++;
        $display("[TB] FAIL combined[%0d]: got stall/clr %b expected %b", i, obs, {exp_s, exp_s});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [8:0] obs;
    logic [8:0] exp;
    Reset = 1'b1;
    idle_inputs();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 49) == 0);
      applyStimulus(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      obs = dut_vec();
      exp = model_vec();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got stall/clr/busy/done/cnt/err %b expected %b", i, obs, exp);
      end
      tick();
    end
    Reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    cyc     = 0;
    m_have  = 1'b0;
    m_start = 0;
    m_n     = 0;
    m_err   = 1'b0;
    Reset   = 1'b1;
    test_reset();
    test_load_use();
    test_zero_and_unused();
    test_div_window();
    test_mult_overlap();
    test_combined();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Decides each cycle whether the instruction in D may advance into the D/E pipeline register or must wait.
- Resolves register-read hazards using Tuse/Tnew against the E and M stages.
- Owns the busy sequencer of the multi-cycle multiply/divide unit and holds back D-stage md instructions until it is free.
- Drives the D/E register clear (bubble insertion) and the PC/F-D register hold.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- D_rs_addr  in  5  rs field of the instruction in D.
- D_rt_addr  in  5  rt field of the instruction in D.
- D_Tuse_rs  in  2  cycles until rs is needed; 3 means not used.
- D_Tuse_rt  in  2  cycles until rt is needed; 3 means not used.
- D_is_md  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register of the instruction in E; 0 means none.
- E_Tnew  in  2  cycles until the E-stage result is available.
- M_A3  in  5  destination register of the instruction in M.
- M_Tnew  in  2  cycles until the M-stage result is available.
- E_md_start  in  1  E holds mult/multu/div/divu this cycle.
- E_md_op  in  1  0 = mult class, 1 = div class.
- Stall  out  1  hold PC and the F/D register (their enables = ~Stall).
- E_RegE_Clr  out  1  clear the D/E register this edge.
- md_busy  out  1  multiply/divide unit is computing.
- md_done  out  1  one-cycle pulse when the unit finishes.
- md_cnt  out  4  remaining busy cycles.
- md_overlap_err  out  1  sticky: E_md_start seen while busy.

Behaviour:
- Reset (synchronous): at a Clk edge with Reset=1, md_busy=0, md_cnt=0, md_done=0, md_overlap_err=0. While Reset=1, Stall=0 and E_RegE_Clr=0 combinationally. Reset overrides every other event, including an active busy count mid-operation.
- Data-hazard stall (combinational):
  - stall_rs = (D_rs_addr!=0) & ((D_rs_addr==E_A3 & E_Tnew>D_Tuse_rs) | (D_rs_addr==M_A3 & M_Tnew>D_Tuse_rs)).
  - stall_rt is the same expression using rt.
  - Register 0 never stalls.
  - Tuse=3 never stalls, because Tnew<=2.
  - Tnew=0 in any stage never stalls; forwarding covers it.
- MD stall (combinational): md_stall = D_is_md & (md_busy | E_md_start).
- Outputs: Stall = ~Reset & (stall_rs | stall_rt | md_stall). E_RegE_Clr = Stall. Together these give exactly one bubble into E per stalled cycle; D and F are held.
- MD FSM states: IDLE (md_busy=0) and BUSY (md_busy=1). Transitions, per Clk edge with Reset=0:
  - IDLE & E_md_start: md_cnt <= E_md_op ? DIV_CYCLES : MULT_CYCLES; md_busy <= 1.
  - IDLE & ~E_md_start: no change; md_cnt holds 0.
  - BUSY & md_cnt>1: md_cnt <= md_cnt-1.
  - BUSY & md_cnt==1: md_cnt <= 0; md_busy <= 0; md_done <= 1 for exactly one cycle.
  - BUSY & E_md_start: the new start is ignored, the count continues, and md_overlap_err <= 1, which stays set until Reset.
- md_done is 0 in every cycle not covered by the md_cnt==1 transition.
- Timing: md_busy is high for exactly N cycles after the start edge. A D-stage md instruction advances in the first cycle where md_busy=0 and E_md_start=0.
- md_done and a new E_md_start in the same cycle is legal: the FSM is in IDLE that cycle and the unit restarts.
- md_cnt width is 4 bits. A parameter value of 0 or greater than 15 is illegal and should be caught by an elaboration-time check.

Test Plan:
- Reset held 2 cycles during BUSY with md_cnt=7 -> md_busy=0, md_cnt=0, Stall=0 on the cycle after the edge; md_overlap_err cleared.
- lw $1 in E (E_A3=1, E_Tnew=2) with D beq reading rs=1 (Tuse_rs=0) -> Stall=1 and E_RegE_Clr=1. Next cycle, with $1 in M and M_Tnew=1: Stall=1. After that: Stall=0.
- D_rs_addr=0 with E_A3=0 and E_Tnew=2 -> Stall=0. Also rt hazard where D_Tuse_rt=3 -> Stall=0.
- E_md_start=1, E_md_op=1, DIV_CYCLES=10 -> md_busy high for 10 cycles, md_cnt 10..1, then md_done pulses once. A D_is_md=1 instruction over the whole window sees Stall=1, and Stall=0 in the md_done cycle.
- E_md_start=1, E_md_op=0, then E_md_start=1 again 2 cycles later -> md_overlap_err=1 (sticky), md_cnt continues 5,4,3...; a mult restarted in the md_done cycle reloads md_cnt=5.
- Data hazard and md stall together -> single Stall=1 per cycle; release only when both clear.
